// File: rtl/wb_openram_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter in front of
// the OpenRAM wrapper.
package wb_openram_pkg;

  // Bus widths of the OpenRAM Wishbone port.
  localparam int unsigned WB_DW   = 32;
  localparam int unsigned WB_AW   = 32;
  localparam int unsigned WB_SELW = 4;

  // Default watchdog: strobe cycles without ack before err is returned.
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;
  localparam int unsigned DEF_CNT_WIDTH      = 5;

  // Arbiter states. Encoding 2'b11 is unreachable and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

  // Master index encoded in last_grant.
  localparam logic LG_M0 = 1'b0;
  localparam logic LG_M1 = 1'b1;

  // Round-robin tie break: the master that did not hold the bus last wins.
  function automatic arb_state_t tie_winner(input logic last_grant);
    return (last_grant == LG_M1) ? GNT0 : GNT1;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus watchdog: counts strobe cycles that go unacknowledged and raises a
// one-cycle timeout pulse on the last permitted cycle. TIMEOUT_CYCLES=0
// disables it. CNT_WIDTH must satisfy 2**CNT_WIDTH > TIMEOUT_CYCLES.
module wb_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_WIDTH      = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stb_i,
  input  logic ack_i,
  input  logic enable_i,
  output logic timeout_o
);

  localparam bit WD_ON = (TIMEOUT_CYCLES != 0);
  // Terminal count: the pulse fires on the TIMEOUT_CYCLES-th waiting cycle,
  // counted from 0 on the first strobe cycle.
  localparam logic [CNT_WIDTH-1:0] TERM_CNT =
    WD_ON ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 waiting;

  assign waiting = enable_i && stb_i && !ack_i;

  // An ack on the terminal cycle suppresses the pulse (ack wins).
  assign timeout_o = WD_ON && waiting && (cnt_q == TERM_CNT);

  // Next count: clear on ack, on idle strobe and after a pulse; else count up.
  always_comb begin
    cnt_d = cnt_q;
    if (!waiting || timeout_o) begin
      cnt_d = '0;
    end else if (WD_ON) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_openram_arbiter.sv
// Two-master to one-slave Wishbone arbiter in front of the OpenRAM wrapper.
// Round-robin at release, bus lock while the granted cyc stays high, and a
// watchdog that returns err to a master whose strobe is never acknowledged.
//
//   state | meaning
//   IDLE  | no grant; arbitrate requests, slave cycle idle
//   GNT0  | master 0 owns the slave port until m0_cyc_i drops
//   GNT1  | master 1 owns the slave port until m1_cyc_i drops
module wb_openram_arbiter
  import wb_openram_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,

  input  logic               m0_cyc_i,
  input  logic               m0_stb_i,
  input  logic               m0_we_i,
  input  logic [WB_SELW-1:0] m0_sel_i,
  input  logic [WB_AW-1:0]   m0_adr_i,
  input  logic [WB_DW-1:0]   m0_dat_i,
  output logic               m0_ack_o,
  output logic               m0_err_o,
  output logic [WB_DW-1:0]   m0_dat_o,

  input  logic               m1_cyc_i,
  input  logic               m1_stb_i,
  input  logic               m1_we_i,
  input  logic [WB_SELW-1:0] m1_sel_i,
  input  logic [WB_AW-1:0]   m1_adr_i,
  input  logic [WB_DW-1:0]   m1_dat_i,
  output logic               m1_ack_o,
  output logic               m1_err_o,
  output logic [WB_DW-1:0]   m1_dat_o,

  output logic               s_cyc_o,
  output logic               s_stb_o,
  output logic               s_we_o,
  output logic [WB_SELW-1:0] s_sel_o,
  output logic [WB_AW-1:0]   s_adr_o,
  output logic [WB_DW-1:0]   s_dat_o,
  input  logic               s_ack_i,
  input  logic [WB_DW-1:0]   s_dat_i
);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       last_grant_q;
  logic       last_grant_d;
  logic       wd_timeout;
  logic       gnt0;
  logic       gnt1;

  assign gnt0 = (state_q == GNT0);
  assign gnt1 = (state_q == GNT1);

  // Next-state: arbitrate in IDLE, hold the grant until the owner drops cyc.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = tie_winner(last_grant_q);
        end else if (m0_cyc_i) begin
          state_d = GNT0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          state_d      = IDLE;
          last_grant_d = LG_M0;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          state_d      = IDLE;
          last_grant_d = LG_M1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and round-robin pointer; reset makes m0 win the first tie.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= LG_M1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Slave-side mux; cyc/stb are gated by reset so a reset drops the cycle at once.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (gnt0) begin
      s_cyc_o = m0_cyc_i && !wb_rst_i;
      s_stb_o = m0_stb_i && !wb_rst_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (gnt1) begin
      s_cyc_o = m1_cyc_i && !wb_rst_i;
      s_stb_o = m1_stb_i && !wb_rst_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_watchdog (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .stb_i     (s_stb_o),
    .ack_i     (s_ack_i),
    .enable_i  (gnt0 || gnt1),
    .timeout_o (wd_timeout)
  );

  // Read data is broadcast; only the granted, strobing master sees ack/err.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = !wb_rst_i && s_ack_i && gnt0 && m0_stb_i;
  assign m1_ack_o = !wb_rst_i && s_ack_i && gnt1 && m1_stb_i;
  assign m0_err_o = !wb_rst_i && wd_timeout && gnt0;
  assign m1_err_o = !wb_rst_i && wd_timeout && gnt1;

endmodule

// File: tb/tb_wb_openram_arbiter.sv
// Directed bench for wb_openram_arbiter: one instance with the default
// watchdog and one with the watchdog disabled, driven by the same stimulus.
module tb_wb_openram_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
  logic        s_ack;
  logic [31:0] s_rdat;

  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdat, m1_rdat;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat;

  logic        m0_ack_z, m0_err_z, m1_ack_z, m1_err_z;
  logic [31:0] m0_rdat_z, m1_rdat_z;
  logic        s_cyc_z, s_stb_z, s_we_z;
  logic [3:0]  s_sel_z;
  logic [31:0] s_adr_z, s_wdat_z;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_openram_arbiter #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(5)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_ack_i(s_ack), .s_dat_i(s_rdat)
  );

  wb_openram_arbiter #(.TIMEOUT_CYCLES(0), .CNT_WIDTH(5)) dut_nowd (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_ack_o(m0_ack_z), .m0_err_o(m0_err_z),
    .m0_dat_o(m0_rdat_z),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_ack_o(m1_ack_z), .m1_err_o(m1_err_z),
    .m1_dat_o(m1_rdat_z),
    .s_cyc_o(s_cyc_z), .s_stb_o(s_stb_z), .s_we_o(s_we_z), .s_sel_o(s_sel_z),
    .s_adr_o(s_adr_z), .s_dat_o(s_wdat_z), .s_ack_i(s_ack), .s_dat_i(s_rdat)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic nxt();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    nxt();
    wb_rst_i = 1'b0;
  endtask

  int err_first, err_cnt, err_cnt_z, ack_cnt;

  initial begin
    wb_rst_i = 1'b1;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
    m0_sel = 4'hF; m1_sel = 4'hF;
    m0_adr = '0; m0_wdat = '0; m1_adr = '0; m1_wdat = '0;
    s_ack = 1'b0; s_rdat = '0;

    // Reset: outputs quiet even with a slave ack present.
    nxt();
    s_ack = 1'b1;
    #1;
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_err", m1_err, 0);
    s_ack = 1'b0;
    nxt();
    wb_rst_i = 1'b0;

    // Single master read: one arbitration cycle, then the slave sees m0.
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h3000_0010;
    #1;
    chk("sm_idle_stb", s_stb, 0);
    nxt();
    chk("sm_stb", s_stb, 1);
    chk("sm_adr", s_adr, 32'h3000_0010);
    s_ack = 1; s_rdat = 32'hDEAD_BEEF;
    #1;
    chk("sm_m0_ack", m0_ack, 1);
    chk("sm_m0_dat", m0_rdat, 32'hDEAD_BEEF);
    chk("sm_m1_ack", m1_ack, 0);
    nxt();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    nxt();

    // Tie after reset: m0 first, one idle cycle, then m1; repeat tie -> m0.
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0100;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0200;
    nxt();
    chk("tie1_adr", s_adr, 32'h0000_0100);
    chk("tie1_cyc", s_cyc, 1);
    nxt();
    m0_cyc = 0; m0_stb = 0;
    nxt();
    chk("tie1_gap_cyc", s_cyc, 0);
    nxt();
    chk("tie1_m1_adr", s_adr, 32'h0000_0200);
    s_ack = 1;
    #1;
    chk("tie1_m1_ack", m1_ack, 1);
    chk("tie1_m0_ack", m0_ack, 0);
    nxt();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    nxt();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    nxt();
    chk("tie2_adr", s_adr, 32'h0000_0100);
    m0_cyc = 0; m0_stb = 0;
    nxt();
    // IDLE with both requesting again; last holder was m0 so m1 wins.
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0300;
    nxt();
    chk("lock_gnt_m1", s_adr, 32'h0000_0200);

    // Bus lock: m1 does three writes toggling stb while m0 keeps requesting.
    for (int i = 0; i < 3; i++) begin
      m1_stb = 1; m1_we = 1; m1_adr = 32'h0000_0500 + 32'(4 * i);
      m1_wdat = 32'hA000_0000 + 32'(i); s_ack = 1;
      #1;
      chk("lock_cyc", s_cyc, 1);
      chk("lock_adr", s_adr, 32'h0000_0500 + 32'(4 * i));
      chk("lock_dat", s_wdat, 32'hA000_0000 + 32'(i));
      chk("lock_m1_ack", m1_ack, 1);
      chk("lock_m0_ack", m0_ack, 0);
      nxt();
      m1_stb = 0;
      #1;
      chk("lock_gap_cyc", s_cyc, 1);
      chk("lock_gap_m0_ack", m0_ack, 0);
      nxt();
    end
    s_ack = 0; m1_cyc = 0; m1_we = 0;
    nxt();
    chk("lock_rel_cyc", s_cyc, 0);
    nxt();
    chk("lock_m0_adr", s_adr, 32'h0000_0300);
    s_ack = 1;
    #1;
    chk("lock_m0_ack_after", m0_ack, 1);
    nxt();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    nxt();

    // Timeout: unmapped address never acked; err on 16th strobe cycle.
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h4000_0000;
    nxt();
    err_first = -1; err_cnt = 0; err_cnt_z = 0; ack_cnt = 0;
    for (int i = 0; i < 22; i++) begin
      #1;
      if (m0_err) begin
        err_cnt++;
        if (err_first < 0) err_first = i;
      end
      if (m0_err_z) err_cnt_z++;
      if (m0_ack) ack_cnt++;
      nxt();
    end
    chk("to_err_cycle", err_first, 15);
    chk("to_err_pulses", err_cnt, 1);
    chk("to_m0_ack", ack_cnt, 0);
    chk("to_nowd_err", err_cnt_z, 0);
    chk("to_grant_held", s_cyc, 1);

    // Ack on the terminal cycle wins over err.
    m0_stb = 0;
    nxt();
    m0_stb = 1;
    err_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (m0_err) err_cnt++;
      nxt();
    end
    s_ack = 1; s_rdat = 32'h1234_5678;
    #1;
    chk("tc_ack", m0_ack, 1);
    chk("tc_err", m0_err, 0);
    chk("tc_early_err", err_cnt, 0);
    chk("tc_dat", m0_rdat, 32'h1234_5678);
    nxt();
    s_ack = 0;

    // Watchdog disabled: 100 unacked cycles, no err, grant held.
    err_cnt = 0; err_cnt_z = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (m0_err) err_cnt++;
      if (m0_err_z) err_cnt_z++;
      nxt();
    end
    chk("nowd_err", err_cnt_z, 0);
    chk("nowd_cyc", s_cyc_z, 1);
    chk("nowd_stb", s_stb_z, 1);
    chk("wd_periodic_err", err_cnt, 6);

    // Reset mid-cycle in GNT1 drops the slave cycle immediately.
    m0_cyc = 0; m0_stb = 0;
    nxt();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0600;
    nxt();
    chk("mr_gnt1_stb", s_stb, 1);
    chk("mr_gnt1_adr", s_adr, 32'h0000_0600);
    wb_rst_i = 1; s_ack = 1;
    #1;
    chk("mr_s_cyc", s_cyc, 0);
    chk("mr_s_stb", s_stb, 0);
    chk("mr_m1_ack", m1_ack, 0);
    nxt();
    wb_rst_i = 0; s_ack = 0;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0700;
    #1;
    chk("mr_idle_cyc", s_cyc, 0);
    nxt();
    chk("mr_tie_m0_adr", s_adr, 32'h0000_0700);
    s_ack = 1;
    #1;
    chk("mr_tie_m0_ack", m0_ack, 1);
    chk("mr_tie_m1_ack", m1_ack, 0);
    nxt();
    s_ack = 0; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_openram_arbiter.md
Name: wb_openram_arbiter

Overview:
- Two-master to one-slave Wishbone arbiter with round-robin grant and a bus watchdog.
- Sits directly upstream of the OpenRAM Wishbone wrapper and drives its single slave port.
- Lets two masters, e.g. the management SoC and a user DMA engine, share one SRAM macro port.
- Masters whose cycle is never acknowledged are released with an error.

Parameters:
TIMEOUT_CYCLES, 16, cycles of stb-without-ack before err is returned to the granted master; 0 disables the watchdog.
CNT_WIDTH, 5, watchdog counter width; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
wb_clk_i  in  1  single clock for all logic
wb_rst_i  in  1  synchronous, active-high reset
m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle, strobe, write enable
m0_sel_i  in  4  master 0 byte select
m0_adr_i  in  32  master 0 address
m0_dat_i  in  32  master 0 write data
m0_ack_o, m0_err_o  out  1 each  master 0 acknowledge, error
m0_dat_o  out  32  master 0 read data
m1_*  same set and widths as m0_*  master 1
s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
s_sel_o  out  4  to slave
s_adr_o, s_dat_o  out  32 each  to slave
s_ack_i  in  1  from slave
s_dat_i  in  32  from slave

Behaviour:
Reset:
- wb_rst_i is sampled on the wb_clk_i rising edge. It sets state=IDLE, last_grant=1 (so m0 wins the first tie) and wd_cnt=0.
- While wb_rst_i is high, s_cyc_o, s_stb_o, m*_ack_o and m*_err_o are forced 0 combinationally. Reset mid-cycle drops the slave cycle the same cycle.

States:
- IDLE: no grant.
  - Only m0_cyc_i high -> GNT0. Only m1_cyc_i high -> GNT1.
  - Both high -> grant the master not equal to last_grant.
  - Neither high -> stay in IDLE.
  - Arbitration takes 1 cycle: a request seen in IDLE reaches the slave on the next cycle.
- GNT0 / GNT1: the grant is held while that master's cyc_i is high.
  - stb may drop and reassert without losing the grant; this is bus-lock semantics.
  - Granted cyc_i low -> IDLE, and last_grant is updated to the releasing master. There is always one idle cycle between grants, including back-to-back handover.

Slave side:
- In GNTx, s_cyc_o/stb/we/sel/adr/dat = mx_*_i combinationally.
- In IDLE, s_cyc_o=s_stb_o=0 and the other s_* outputs are 0.

Master side:
- m0_dat_o = m1_dat_o = s_dat_i, broadcast.
- mx_ack_o = s_ack_i & (state==GNTx) & mx_stb_i.
- A non-granted master never sees ack or err.

Watchdog:
- wd_cnt increments each cycle with s_stb_o=1 and s_ack_i=0.
- wd_cnt clears on s_ack_i, on s_stb_o=0, and on err.
- When wd_cnt==TIMEOUT_CYCLES-1 and s_ack_i=0, mx_err_o pulses for 1 cycle and the counter clears. The master must then end or retry. The grant is unaffected.
- ack and err are never both high; if ack arrives on the terminal-count cycle, ack wins.
- TIMEOUT_CYCLES=0 means err is never asserted.

Simultaneous events:
- Granted master drops cyc in the same cycle the other raises it: go to IDLE, then the other is granted next cycle.
- A master raising cyc during the other's grant waits without limit. Fairness is round-robin at release only.

Unmapped addresses (outside the wrapper window) never ack; the watchdog is the only recovery.

Decomposition:
- Package wb_openram_pkg:
  - state enum arb_state_t {IDLE, GNT0, GNT1}
  - constants WB_DW=32, WB_AW=32, WB_SELW=4
  - default TIMEOUT_CYCLES
- One sub-module, wb_arb_watchdog:
  - inputs: clk, rst, stb, ack, enable
  - output: timeout pulse
  - parameterised by TIMEOUT_CYCLES and CNT_WIDTH
- The arbiter top holds the FSM, last_grant and the muxes.

Test Plan:
- Single master: m0 reads 0x3000_0010 from an idle bus.
  - s_stb_o rises 1 cycle after m0_cyc_i, with s_adr_o=0x3000_0010.
  - A slave ack with s_dat_i=0xDEADBEEF gives m0_ack_o=1 and m0_dat_o=0xDEADBEEF. m1_ack_o stays 0.
- Tie after reset: m0 and m1 raise cyc in the same cycle.
  - GNT0 first. After m0 drops cyc: 1 IDLE cycle, then GNT1.
  - Repeat the tie: GNT0 again, because last_grant=1.
- Bus lock: m1 granted, holds cyc, toggles stb over 3 writes while m0 requests throughout.
  - s_cyc_o tracks m1 for all 3 writes; m0 gets no ack until m1 releases.
- Timeout: m0 accesses 0x4000_0000 and the slave never acks, TIMEOUT_CYCLES=16.
  - m0_err_o pulses exactly 16 cycles after s_stb_o rises; m0_ack_o stays 0.
  - Ack on cycle 16 instead gives ack=1, err=0.
- Reset mid-cycle: wb_rst_i=1 while in GNT1 with stb high.
  - s_cyc_o=s_stb_o=0 in the same cycle.
  - After release the state is IDLE and the next tie grants m0.
- Watchdog disabled: TIMEOUT_CYCLES=0 and a never-acking slave.
  - No err within 100 cycles; the grant is held.
